message_packer: RTL and testbench



---
 rtl/sha_pkg.sv | 33 +++
 rtl/message_packer.sv | 142 ++++++++++++++
 tb/tb_message_packer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA message front end.
// Used by message_packer and message_build.
package sha_pkg;

  localparam int BLOCK_W         = 512;
  localparam int WORD_W          = 32;
  localparam int SIZE_W          = 64;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  // ceil(size/32) needs one bit more than size[63:5] for 2^64-1
  localparam int LEFT_W = SIZE_W - 4;

  typedef logic [1:0] scheme_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CFG,
    ST_FILL,
    ST_SEND
  } pk_state_e;

  // Keep the top tail_bits bits of a word; zero tail means whole word.
  function automatic logic [WORD_W-1:0] tail_mask(
    input logic [4:0] tail_bits
  );
    logic [WORD_W-1:0] m;
    m = '1;
    if (tail_bits != 5'd0)
      m = ~({WORD_W{1'b1}} >> tail_bits);
    return m;
  endfunction

endpackage

// File: rtl/message_packer.sv
// Packs a 32-bit word stream big-endian into 512-bit blocks.
// Forwards per-message cfg ahead of the blocks.
module message_packer
  import sha_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [SIZE_W-1:0]     cfg_in_size,
  input  scheme_t               cfg_in_scheme,
  input  logic                  cfg_in_valid,
  output logic                  cfg_in_ready,
  input  logic [WORD_W-1:0]     word_in,
  input  logic                  word_in_valid,
  output logic                  word_in_ready,
  output logic [SIZE_W-1:0]     cfg_size,
  output scheme_t               cfg_scheme,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic [BLOCK_W-1:0]    data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  pk_state_e          state_q, state_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  scheme_t            scheme_q, scheme_d;
  logic [LEFT_W-1:0]  left_q, left_d;
  logic [4:0]         tail_q, tail_d;
  logic [3:0]         idx_q, idx_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;

  logic [WORD_W-1:0]  wmask;
  logic               last_word;

  assign last_word = (left_q == LEFT_W'(1));

  // Only the final word of a message gets its trailing bits cleared
  always_comb begin
    wmask = '1;
    if (last_word)
      wmask = tail_mask(tail_q);
  end

  // Handshake outputs decode straight from the state register
  always_comb begin
    cfg_in_ready   = 1'b0;
    cfg_valid      = 1'b0;
    word_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    unique case (1'b1)
      state_q == ST_IDLE: cfg_in_ready   = 1'b1;
      state_q == ST_CFG:  cfg_valid      = 1'b1;
      state_q == ST_FILL: word_in_ready  = 1'b1;
      state_q == ST_SEND: data_out_valid = 1'b1;
      default: ;
    endcase
  end

  assign cfg_size   = size_q;
  assign cfg_scheme = scheme_q;
  assign data_out   = buf_q;

  // Next-state: cfg latch, block fill and block hand-off
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    scheme_d = scheme_q;
    left_d   = left_q;
    tail_d   = tail_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_in_valid) begin
          size_d   = cfg_in_size;
          scheme_d = cfg_in_scheme;
          left_d   = {1'b0, cfg_in_size[SIZE_W-1:5]}
                   + LEFT_W'(|cfg_in_size[4:0]);
          tail_d   = cfg_in_size[4:0];
          state_d  = ST_CFG;
        end
      end
      ST_CFG: begin
        if (cfg_ready) begin
          if (left_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            buf_d   = '0;
            idx_d   = '0;
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (word_in_valid) begin
          for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            if (idx_q == 4'(k))
              buf_d[BLOCK_W-1-WORD_W*k -: WORD_W] = word_in & wmask;
          end
          idx_d  = idx_q + 4'd1;
          left_d = left_q - LEFT_W'(1);
          if (idx_q == 4'd15 || last_word)
            state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (data_out_ready) begin
          if (left_q != '0) begin
            buf_d   = '0;
            idx_d   = '0;
            state_d = ST_FILL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      size_q   <= '0;
      scheme_q <= '0;
      left_q   <= '0;
      tail_q   <= '0;
      idx_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      scheme_q <= scheme_d;
      left_q   <= left_d;
      tail_q   <= tail_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: tb/tb_message_packer.sv
// Directed bench for message_packer.
// Expected blocks are built from the word tables.
module tb_message_packer;

  logic         clk = 1'b0;
  logic         nrst;
  logic [63:0]  cfg_in_size;
  logic [1:0]   cfg_in_scheme;
  logic         cfg_in_valid;
  logic         cfg_in_ready;
  logic [31:0]  word_in;
  logic         word_in_valid;
  logic         word_in_ready;
  logic [63:0]  cfg_size;
  logic [1:0]   cfg_scheme;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [511:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  message_packer dut (
    .clk            (clk),
    .nrst           (nrst),
    .cfg_in_size    (cfg_in_size),
    .cfg_in_scheme  (cfg_in_scheme),
    .cfg_in_valid   (cfg_in_valid),
    .cfg_in_ready   (cfg_in_ready),
    .word_in        (word_in),
    .word_in_valid  (word_in_valid),
    .word_in_ready  (word_in_ready),
    .cfg_size       (cfg_size),
    .cfg_scheme     (cfg_scheme),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [63:0] sz,
                          input logic [1:0] sc);
    int n = 0;
    cfg_in_size   = sz;
    cfg_in_scheme = sc;
    cfg_in_valid  = 1'b1;
    while (!cfg_in_ready && n < 50) begin
      step();
      n++;
    end
    chk("cfg_in_ready", cfg_in_ready, 1);
    step();
    cfg_in_valid = 1'b0;
  endtask

  task automatic accept_cfg(input string tag,
                            input logic [63:0] sz,
                            input logic [1:0] sc);
    int n = 0;
    while (!cfg_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_cfg_valid"}, cfg_valid, 1);
    chk({tag, "_cfg_size"}, cfg_size, sz);
    chk({tag, "_cfg_scheme"}, cfg_scheme, sc);
    cfg_ready = 1'b1;
    step();
    cfg_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    word_in       = w;
    word_in_valid = 1'b1;
    while (!word_in_ready && n < 50) begin
      step();
      n++;
    end
    if (!word_in_ready)
      chk("word_in_ready_timeout", word_in_ready, 1);
    step();
    word_in_valid = 1'b0;
  endtask

  task automatic recv_block(input string tag,
                            input logic [511:0] exp,
                            input int hold);
    int n = 0;
    logic [511:0] snap;
    while (!data_out_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, data_out_valid, 1);
    snap = data_out;
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold"},
          {data_out_valid, word_in_ready, data_out},
          {1'b1, 1'b0, snap});
    end
    data_out_ready = 1'b1;
    chk({tag, "_data"}, data_out, exp);
    step();
    data_out_ready = 1'b0;
  endtask

  logic [511:0] exp;
  logic [511:0] exp2;
  int t0;
  int bad;

  initial begin
    nrst           = 1'b0;
    cfg_in_size    = '0;
    cfg_in_scheme  = '0;
    cfg_in_valid   = 1'b0;
    word_in        = '0;
    word_in_valid  = 1'b0;
    cfg_ready      = 1'b0;
    data_out_ready = 1'b0;
    step();
    step();
    chk("rst_out",
        {cfg_in_ready, cfg_valid, word_in_ready, data_out_valid,
         cfg_size, cfg_scheme, data_out},
        {1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0, 512'd0});
    nrst = 1'b1;
    step();
    chk("post_rst_idle", {cfg_in_ready, cfg_valid}, 2'b10);

    // 448 bits: 14 words, slots 14..15 stay zero
    send_cfg(64'd448, 2'd2);
    chk("448_cfg_lat", cfg_valid, 1);
    accept_cfg("448", 64'd448, 2'd2);
    chk("448_fill_lat", word_in_ready, 1);
    exp = '0;
    for (int k = 0; k < 14; k++) begin
      send_word(32'(k + 1));
      exp[511-32*k -: 32] = 32'(k + 1);
    end
    chk("448_send_lat", data_out_valid, 1);
    recv_block("448", exp, 0);
    chk("448_idle", {cfg_in_ready, data_out_valid, word_in_ready},
        3'b100);

    // 512 bits: one full block in 16 cycles, extra word refused
    send_cfg(64'd512, 2'd1);
    accept_cfg("512", 64'd512, 2'd1);
    exp = '0;
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      send_word(32'hA000_0000 + 32'(k));
      exp[511-32*k -: 32] = 32'hA000_0000 + 32'(k);
    end
    chk("512_fill_cycles", 32'(cyc - t0), 32'd16);
    chk("512_send_lat", data_out_valid, 1);
    recv_block("512", exp, 0);
    word_in       = 32'hDEAD_BEEF;
    word_in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (word_in_ready) bad++;
      step();
    end
    word_in_valid = 1'b0;
    chk("512_extra_word", 32'(bad), 32'd0);

    // 520 bits: two blocks, last word cut to its top 8 bits
    send_cfg(64'd520, 2'd3);
    accept_cfg("520", 64'd520, 2'd3);
    exp = '0;
    for (int k = 0; k < 16; k++) begin
      send_word(32'h0101_0101 * 32'(k + 1));
      exp[511-32*k -: 32] = 32'h0101_0101 * 32'(k + 1);
    end
    recv_block("520_b1", exp, 0);
    chk("520_refill_lat", word_in_ready, 1);
    send_word(32'hFFFF_FFFF);
    exp2 = '0;
    exp2[511:480] = 32'hFF00_0000;
    recv_block("520_b2", exp2, 0);
    chk("520_idle", cfg_in_ready, 1);

    // zero length: cfg forwarded, no block
    send_cfg(64'd0, 2'd1);
    accept_cfg("zero", 64'd0, 2'd1);
    chk("zero_idle", cfg_in_ready, 1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (data_out_valid || word_in_ready) bad++;
      step();
    end
    chk("zero_no_block", 32'(bad), 32'd0);

    // backpressure: 10 stalled SEND cycles
    send_cfg(64'd448, 2'd0);
    accept_cfg("bp", 64'd448, 2'd0);
    exp = '0;
    for (int k = 0; k < 14; k++) begin
      send_word(32'h5A5A_0000 ^ 32'(k * 3));
      exp[511-32*k -: 32] = 32'h5A5A_0000 ^ 32'(k * 3);
    end
    recv_block("bp", exp, 10);
    chk("bp_idle", {cfg_in_ready, data_out_valid}, 2'b10);

    // reset mid-message discards partial block
    send_cfg(64'd448, 2'd2);
    accept_cfg("rst", 64'd448, 2'd2);
    for (int k = 0; k < 7; k++)
      send_word(32'hC0DE_0000 + 32'(k));
    nrst = 1'b0;
    #1;
    chk("rst_mid",
        {cfg_in_ready, cfg_valid, word_in_ready, data_out_valid,
         cfg_size, cfg_scheme, data_out},
        {1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'd0, 512'd0});
    step();
    nrst = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (cfg_valid || data_out_valid || word_in_ready) bad++;
    end
    chk("rst_quiet", 32'(bad), 32'd0);
    send_cfg(64'd448, 2'd2);
    accept_cfg("rst2", 64'd448, 2'd2);
    exp = '0;
    for (int k = 0; k < 14; k++) begin
      send_word(32'h1234_0000 + 32'(k));
      exp[511-32*k -: 32] = 32'h1234_0000 + 32'(k);
    end
    recv_block("rst2", exp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
